// File: rtl/divider_32b.sv
// 32-bit sequential restoring divider, one quotient bit per cycle.
// Signed operation divides magnitudes and then corrects the signs of the result.
module divider_32b #(
  parameter int unsigned SIGNED_MODE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        finish,
  output logic        div_by_zero
);

  localparam bit SGN = (SIGNED_MODE != 0);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ITER,
    FIXUP,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_dvd_lat;
  logic [31:0] r_dvs_lat;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [32:0] r_rem;
  logic [5:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dbz;
  logic [31:0] r_quotient;
  logic [31:0] r_remainder;

  logic        w_accept;
  logic [31:0] w_dvd_abs;
  logic [31:0] w_dvs_abs;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic        w_take;
  logic        w_zero_dvs;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

  assign w_dvd_abs = (SGN && r_dvd_lat[31]) ? (32'd0 - r_dvd_lat) : r_dvd_lat;
  assign w_dvs_abs = (SGN && r_dvs_lat[31]) ? (32'd0 - r_dvs_lat) : r_dvs_lat;

  // A set bit 32 means the shifted remainder exceeds any 32-bit divisor.
  assign w_shift = {r_rem[31:0], r_quo[31]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_take  = r_rem[32] | ~w_trial[32];

  assign w_zero_dvs = (r_dvs == 32'd0);
  assign w_q_fix    = r_neg_q ? (32'd0 - r_quo) : r_quo;
  assign w_r_fix    = r_neg_r ? (32'd0 - r_rem[31:0]) : r_rem[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = INIT;
      INIT:    w_next = ITER;
      ITER:    if (r_cnt == 6'd0) w_next = FIXUP;
      FIXUP:   w_next = DONE;
      DONE:    if (start) w_next = INIT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd_lat   <= '0;
      r_dvs_lat   <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      if (w_accept) begin
        r_dvd_lat <= dividend;
        r_dvs_lat <= divisor;
        r_dbz     <= 1'b0;
      end
      case (r_state)
        INIT: begin
          r_quo   <= w_dvd_abs;
          r_dvs   <= w_dvs_abs;
          r_rem   <= '0;
          r_cnt   <= 6'd31;
          r_neg_q <= SGN && (r_dvd_lat[31] ^ r_dvs_lat[31]);
          r_neg_r <= SGN && r_dvd_lat[31];
        end
        ITER: begin
          r_rem <= w_take ? w_trial : w_shift;
          r_quo <= {r_quo[30:0], w_take};
          r_cnt <= r_cnt - 6'd1;
        end
        FIXUP: begin
          // Divide-by-zero reports the raw dividend, bypassing sign correction.
          r_quotient  <= w_zero_dvs ? '1 : w_q_fix;
          r_remainder <= w_zero_dvs ? r_dvd_lat : w_r_fix;
          r_dbz       <= w_zero_dvs;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = (r_state == INIT) || (r_state == ITER) || (r_state == FIXUP);
  assign finish      = (r_state == DONE);
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_32b.sv
// Directed-vector bench: a signed and an unsigned divider share the same stimulus.
module tb_divider_32b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;

  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic        busy_s, fin_s, dbz_s, busy_u, fin_u, dbz_u;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  divider_32b #(.SIGNED_MODE(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quo_s), .remainder(rem_s), .busy(busy_s), .finish(fin_s),
    .div_by_zero(dbz_s)
  );

  divider_32b #(.SIGNED_MODE(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quo_u), .remainder(rem_u), .busy(busy_u), .finish(fin_u),
    .div_by_zero(dbz_u)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Accepting edge is edge 1; finish must rise at edge 35.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                        input logic cu, input logic [31:0] equ, input logic [31:0] eru,
                        input int pa, input int pb);
    int e;
    int nb;
    logic [31:0] pq_s, pr_s, pq_u;
    pq_s = quo_s;
    pr_s = rem_s;
    pq_u = quo_u;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    e = 1;
    start = 1'b0; dividend = ~a; divisor = ~b;
    chk("fin_drop_acc", {31'b0, fin_s}, 32'd0);
    chk("dbz_drop_acc", {31'b0, dbz_s}, 32'd0);
    chk("hold_q_acc", quo_s, pq_s);
    nb = busy_s ? 1 : 0;
    while (!fin_s && e < 40) begin
      if (e + 1 == pa || e + 1 == pb) begin
        start = 1'b1; dividend = 32'd10; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      e++;
      if (e == 34) begin
        chk("hold_q_s", quo_s, pq_s);
        chk("hold_r_s", rem_s, pr_s);
        chk("hold_q_u", quo_u, pq_u);
      end
      if (busy_s && e < 35) nb++;
    end
    start = 1'b0;
    chk("latency", e, 32'd35);
    chk("busy_edges", nb, 32'd34);
    chk("busy_end", {31'b0, busy_s}, 32'd0);
    chk("quo_s", quo_s, eq);
    chk("rem_s", rem_s, er);
    chk("dbz_s", {31'b0, dbz_s}, {31'b0, edbz});
    if (cu) begin
      chk("fin_u", {31'b0, fin_u}, 32'd1);
      chk("quo_u", quo_u, equ);
      chk("rem_u", rem_u, eru);
      chk("dbz_u", {31'b0, dbz_u}, {31'b0, edbz});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_q"},    quo_s, 32'd0);
    chk({tag, "_r"},    rem_s, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy_s}, 32'd0);
    chk({tag, "_fin"},  {31'b0, fin_s}, 32'd0);
    chk({tag, "_dbz"},  {31'b0, dbz_s}, 32'd0);
  endtask

  initial begin
    int e;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    @(posedge clk); @(posedge clk); #1;
    chk_zero("rst");
    @(negedge clk); rst_n = 1'b1;

    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, 32'd14, 32'd2, 0, 0);
    run_op(-32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, '0, '0, 0, 0);
    run_op(32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2, 1'b0, 1'b1, 32'd0, 32'd100, 0, 0);
    run_op(32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h7FFFFFFF, 32'd1, 0, 0);
    run_op(32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd1234, 0, 0);
    run_op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0,
           1'b1, 32'd0, 32'h80000000, 5, 20);

    // Reset asserted partway through an operation.
    @(negedge clk);
    start = 1'b1; dividend = 32'd55; divisor = 32'd5;
    @(posedge clk); #1;
    e = 1;
    start = 1'b0;
    while (e < 17) begin
      @(posedge clk); #1;
      e++;
    end
    #1 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, 32'd14, 32'd2, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
